// File: rtl/ahb_addr_arbiter.sv
// rtl/ahb_addr_arbiter.sv - round-robin AHB address-phase arbiter and incrementing burst sequencer
// Optional ADDR_HOLD_CHECK_EN compiles in bus-protocol assertions.
module ahb_addr_arbiter #(
    parameter int NUM_M  = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic [NUM_M-1:0]         req,
    input  logic [NUM_M*ADDR_W-1:0]  m_addr,
    input  logic [NUM_M*LEN_W-1:0]   m_len,
    input  logic                     hready,
    output logic [NUM_M-1:0]         grant,
    output logic [ADDR_W-1:0]        haddr,
    output logic [1:0]               htrans,
    output logic                     busy,
    output logic                     done
);

    localparam int RR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic {ST_IDLE, ST_XFER} state_e;

    state_e              state_q, state_d;
    logic [NUM_M-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic [1:0]          htrans_q, htrans_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [RR_W-1:0]     rr_q, rr_d;
    logic                done_q, done_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_M];
    logic [LEN_W-1:0]    len_arr  [NUM_M];
    logic                win_found;
    logic [RR_W-1:0]     win_idx;
    logic [RR_W-1:0]     cand;

    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            addr_arr[i] = m_addr[i*ADDR_W +: ADDR_W];
            len_arr[i]  = m_len[i*LEN_W +: LEN_W];
        end
    end

    // First set request at or above rr_q, wrapping back to index 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (int'(rr_q) + k >= NUM_M)
                cand = RR_W'(int'(rr_q) + k - NUM_M);
            else
                cand = RR_W'(int'(rr_q) + k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        rem_d    = rem_q;
        rr_d     = rr_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    haddr_d          = addr_arr[win_idx] & ~ADDR_W'(3);
                    htrans_d         = HT_NONSEQ;
                    rem_d            = len_arr[win_idx];
                    rr_d             = (win_idx == RR_W'(NUM_M - 1)) ? '0 : win_idx + RR_W'(1);
                    state_d          = ST_XFER;
                end
            end
            ST_XFER: begin
                if (hready) begin
                    if (rem_q != '0) begin
                        haddr_d  = haddr_q + ADDR_W'(4);
                        htrans_d = HT_SEQ;
                        rem_d    = rem_q - LEN_W'(1);
                    end else begin
                        grant_d  = '0;
                        htrans_d = HT_IDLE;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            haddr_q  <= '0;
            htrans_q <= HT_IDLE;
            rem_q    <= '0;
            rr_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            rem_q    <= rem_d;
            rr_q     <= rr_d;
            done_q   <= done_d;
        end
    end

    assign grant  = grant_q;
    assign haddr  = haddr_q;
    assign htrans = htrans_q;
    assign done   = done_q;
    assign busy   = (state_q == ST_XFER) && !hready;

`ifdef ADDR_HOLD_CHECK_EN
    a_addr_hold: assert property (@(posedge hclk) disable iff (!hresetn)
        busy |=> $stable(haddr))
        else $error("address changed during stall, haddr=%h", haddr);

    a_grant_onehot0: assert property (@(posedge hclk) disable iff (!hresetn)
        $onehot0(grant))
        else $error("grant not onehot0, haddr=%h", haddr);

    a_nonseq_start: assert property (@(posedge hclk) disable iff (!hresetn)
        htrans == HT_NONSEQ |-> $rose(|grant) || $past(done))
        else $error("NONSEQ without new grant, haddr=%h", haddr);
`endif

endmodule

// File: tb/tb_ahb_addr_arbiter.sv
// tb/tb_ahb_addr_arbiter.sv - directed table-driven bench for ahb_addr_arbiter
module tb_ahb_addr_arbiter;

    logic         hclk = 1'b0;
    logic         hresetn;
    logic [3:0]   req;
    logic [127:0] m_addr;
    logic [15:0]  m_len;
    logic         hready;
    logic [3:0]   grant;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    ahb_addr_arbiter #(.NUM_M(4), .ADDR_W(32), .LEN_W(4)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .req     (req),
        .m_addr  (m_addr),
        .m_len   (m_len),
        .hready  (hready),
        .grant   (grant),
        .haddr   (haddr),
        .htrans  (htrans),
        .busy    (busy),
        .done    (done)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        rstn;
        logic [3:0]  req;
        logic [31:0] a0;
        logic [3:0]  l0;
        logic        hr;
        logic [3:0]  e_grant;
        logic [31:0] e_haddr;
        logic [1:0]  e_htrans;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rstn, input logic [3:0] r, input logic [31:0] a0,
                                input logic [3:0] l0, input logic hr, input logic [3:0] g,
                                input logic [31:0] ha, input logic [1:0] ht, input logic b,
                                input logic d);
        vec_t v;
        v.rstn = rstn; v.req = r; v.a0 = a0; v.l0 = l0; v.hr = hr;
        v.e_grant = g; v.e_haddr = ha; v.e_htrans = ht; v.e_busy = b; v.e_done = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [31:0] ha,
                           input logic [1:0] ht, input logic b, input logic d);
        chk({tag, ".grant"},  32'(grant),  32'(g));
        chk({tag, ".haddr"},  haddr,       ha);
        chk({tag, ".htrans"}, 32'(htrans), 32'(ht));
        chk({tag, ".busy"},   32'(busy),   32'(b));
        chk({tag, ".done"},   32'(done),   32'(d));
    endtask

    initial begin
        bit seen;

        // single burst
        vecs.push_back(mk(1, 4'b0001, 32'h100, 4'd3, 1, 4'b0000, 32'h500, 2'b00, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0001, 32'h100, 2'b10, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0001, 32'h104, 2'b11, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0001, 32'h108, 2'b11, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0001, 32'h10C, 2'b11, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0000, 32'h10C, 2'b00, 0, 1));
        // wait states on beat 2
        vecs.push_back(mk(1, 4'b0001, 32'h100, 4'd3, 1, 4'b0000, 32'h10C, 2'b00, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0001, 32'h100, 2'b10, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 0, 4'b0001, 32'h104, 2'b11, 1, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 0, 4'b0001, 32'h104, 2'b11, 1, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0001, 32'h104, 2'b11, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0001, 32'h108, 2'b11, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0001, 32'h10C, 2'b11, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h100, 4'd3, 1, 4'b0000, 32'h10C, 2'b00, 0, 1));
        // reset returns the round-robin pointer to 0
        vecs.push_back(mk(0, 4'b0000, 32'h200, 4'd0, 1, 4'b0000, 32'h10C, 2'b00, 0, 0));
        // round robin between 0 and 2
        vecs.push_back(mk(1, 4'b0101, 32'h200, 4'd0, 1, 4'b0000, 32'h000, 2'b00, 0, 0));
        vecs.push_back(mk(1, 4'b0101, 32'h200, 4'd0, 1, 4'b0001, 32'h200, 2'b10, 0, 0));
        vecs.push_back(mk(1, 4'b0101, 32'h200, 4'd0, 1, 4'b0000, 32'h200, 2'b00, 0, 1));
        vecs.push_back(mk(1, 4'b0101, 32'h200, 4'd0, 1, 4'b0100, 32'h300, 2'b10, 0, 0));
        vecs.push_back(mk(1, 4'b0101, 32'h200, 4'd0, 1, 4'b0000, 32'h300, 2'b00, 0, 1));
        vecs.push_back(mk(1, 4'b0101, 32'h200, 4'd0, 1, 4'b0001, 32'h200, 2'b10, 0, 0));
        vecs.push_back(mk(1, 4'b0101, 32'h200, 4'd0, 1, 4'b0000, 32'h200, 2'b00, 0, 1));
        vecs.push_back(mk(1, 4'b0101, 32'h200, 4'd0, 1, 4'b0100, 32'h300, 2'b10, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h200, 4'd0, 1, 4'b0000, 32'h300, 2'b00, 0, 1));
        // address wrap, low address bits ignored
        vecs.push_back(mk(1, 4'b0001, 32'hFFFF_FFFE, 4'd1, 1, 4'b0000, 32'h300, 2'b00, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'hFFFF_FFFE, 4'd1, 1, 4'b0001, 32'hFFFF_FFFC, 2'b10, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'hFFFF_FFFE, 4'd1, 1, 4'b0001, 32'h0000_0000, 2'b11, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'hFFFF_FFFE, 4'd1, 1, 4'b0000, 32'h0000_0000, 2'b00, 0, 1));
        // request dropped after grant
        vecs.push_back(mk(1, 4'b1000, 32'h0, 4'd0, 1, 4'b0000, 32'h000, 2'b00, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h0, 4'd0, 1, 4'b1000, 32'h400, 2'b10, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h0, 4'd0, 1, 4'b1000, 32'h404, 2'b11, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h0, 4'd0, 1, 4'b1000, 32'h408, 2'b11, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 32'h0, 4'd0, 1, 4'b0000, 32'h408, 2'b00, 0, 1));
        vecs.push_back(mk(1, 4'b0000, 32'h0, 4'd0, 1, 4'b0000, 32'h408, 2'b00, 0, 0));

        // power-on reset
        hresetn = 1'b0; req = '0; hready = 1'b1; m_addr = '0; m_len = '0;
        repeat (3) @(posedge hclk);
        #1 hresetn = 1'b1;
        @(negedge hclk);
        chk_all("por", 4'b0000, 32'h0, 2'b00, 1'b0, 1'b0);

        // reset mid-burst: long burst from requester 0, abandoned by a 2-cycle reset
        @(posedge hclk); #1;
        req = 4'b0001; m_addr[31:0] = 32'h80; m_len[3:0] = 4'd15;
        @(posedge hclk); #1 req = '0;
        @(posedge hclk); #1;
        @(negedge hclk);
        chk("mid.haddr_before", haddr, 32'h84);
        hresetn = 1'b0; hready = 1'b0;
        @(posedge hclk); @(negedge hclk);
        chk_all("rst1", 4'b0000, 32'h0, 2'b00, 1'b0, 1'b0);
        @(posedge hclk); #1 hresetn = 1'b1;
        @(negedge hclk);
        chk_all("rst2", 4'b0000, 32'h0, 2'b00, 1'b0, 1'b0);
        @(posedge hclk); @(negedge hclk);
        chk("rst.no_done", 32'(done), 32'h0);

        // fresh grant to requester 1 after reset
        hready = 1'b1; req = 4'b0010; m_addr[63:32] = 32'h500; m_len[7:4] = 4'd0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge hclk);
            if (grant != 4'b0000) seen = 1'b1;
        end
        chk("fresh.grant_seen", 32'(seen), 32'h1);
        chk("fresh.grant", 32'(grant), 32'h2);
        chk("fresh.haddr", haddr, 32'h500);
        chk("fresh.htrans", 32'(htrans), 32'h2);
        req = '0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge hclk);
            if (done) seen = 1'b1;
        end
        chk("fresh.done_seen", 32'(seen), 32'h1);

        // table-driven vectors
        for (int n = 0; n < vecs.size(); n++) begin
            @(posedge hclk); #1;
            hresetn = vecs[n].rstn;
            req     = vecs[n].req;
            hready  = vecs[n].hr;
            m_addr  = {32'h400, 32'h300, 32'h500, vecs[n].a0};
            m_len   = {4'd2, 4'd0, 4'd0, vecs[n].l0};
            @(negedge hclk);
            chk_all($sformatf("vec%0d", n), vecs[n].e_grant, vecs[n].e_haddr,
                    vecs[n].e_htrans, vecs[n].e_busy, vecs[n].e_done);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_addr_arbiter.md
# ahb_addr_arbiter

Round-robin address-phase arbiter and burst sequencer for the shared AHB-lite-style address bus on `hclk`. Up to `NUM_M` requesters each post a start address and a beat count. The block grants one requester at a time and drives `haddr`/`htrans` for an incrementing word burst. While the slave stalls, it asserts `busy` and holds `haddr` stable. This is the guarantee checked by the bus property "busy |=> $past(haddr,1)==haddr".

## Interface
- `NUM_M`, 4: number of requesters (2..8).
- `ADDR_W`, 32: address width.
- `LEN_W`, 4: beat-count field width; burst length is `m_len+1` beats.

Ports:
- `hclk`  in  1  clock; all logic on the rising edge.
- `hresetn`  in  1  reset, synchronous, active-low.
- `req`  in  `NUM_M`  per-requester burst request, level.
- `m_addr`  in  `NUM_M*ADDR_W`  start address, requester i at bits `[i*ADDR_W +: ADDR_W]`; word aligned (bits [1:0] ignored, treated as 0).
- `m_len`  in  `NUM_M*LEN_W`  beats minus one, requester i at `[i*LEN_W +: LEN_W]`.
- `hready`  in  1  slave ready; a beat is accepted on an edge with `hready`=1.
- `grant`  out  `NUM_M`  one-hot owner of the current burst; 0 when idle.
- `haddr`  out  `ADDR_W`  current beat address.
- `htrans`  out  2  00 IDLE, 10 NONSEQ (first beat), 11 SEQ (later beats).
- `busy`  out  1  combinational: in XFER and `hready`=0.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- State machine: IDLE, XFER.
- **Reset** (edge with `hresetn`=0):
  - Outputs: `grant`=0, `haddr`=0, `htrans`=00, `done`=0, and `busy`=0 (because state is IDLE).
  - Round-robin pointer `rr`=0, state IDLE.
  - Applies mid-burst too. The burst is abandoned and no `done` is issued.
- **IDLE**: `done` clears at the next edge.
  - If any `req` bit is set, pick the winner: the first set bit searching from index `rr` upward, wrapping at `NUM_M`.
  - Register `grant`=onehot(w), `haddr`={m_addr[w][ADDR_W-1:2],2'b00}, `htrans`=10, `remaining`=m_len[w], `rr`=(w+1) mod `NUM_M`.
  - Go to XFER.
- **XFER, edge with `hready`=0**: hold every output and `remaining` unchanged.
- **XFER, edge with `hready`=1 and `remaining`>0**:
  - `haddr`=`haddr`+4, computed modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0.
  - `htrans`=11, `remaining`-=1.
- **XFER, edge with `hready`=1 and `remaining`=0** (last beat accepted):
  - `grant`=0, `htrans`=00, `done`=1, go to IDLE.
  - `haddr` holds its last value.
- **Requests during a burst**:
  - `req`, `m_addr` and `m_len` are sampled only in IDLE.
  - Dropping `req` mid-burst has no effect; the burst runs to completion.
  - A single requester holding `req` high is re-granted after one IDLE cycle.
- **Invariants**:
  - `grant` is always zero or one-hot.
  - `busy`=1 at edge N implies `haddr` at N+1 equals `haddr` at N.

## Timing
- Grant latency: `req` sampled at edge N in IDLE gives `grant`, `haddr` and `htrans`=10 valid after edge N.
- Burst of L=`m_len`+1 beats with no wait states: XFER lasts exactly L cycles; `done` is high for the one cycle after that.
- Each `hready`=0 cycle extends XFER by exactly one cycle.
- Back-to-back bursts: at least one IDLE cycle between them, so the minimum period is L+1 cycles.
- `busy` has zero latency from `hready`; every other output is registered.

## Configuration
- `ADDR_HOLD_CHECK_EN` defined: compiles in concurrent assertions clocked on `hclk` and disabled while `!hresetn`:
  - `busy |=> $stable(haddr)`.
  - `$onehot0(grant)`.
  - `htrans==2'b10 |-> $rose(|grant) || $past(done)`.
  - Failures `$error` with the current `haddr`.
- Not defined: no assertion code. Functional behaviour is identical either way.

## Test plan
- **Reset**: hold `hresetn`=0 for 2 cycles mid-burst, then release → `grant`=0, `haddr`=0, `htrans`=00, `busy`=0, `done`=0; the next `req[1]` is granted fresh.
- **Single burst**: `req[0]`, `m_addr`=0x100, `m_len`=3, `hready`=1 → `haddr` 0x100, 0x104, 0x108, 0x10C; `htrans` 10, 11, 11, 11; `done` pulses on cycle 5.
- **Wait states**: same burst with `hready`=0 for 2 cycles on beat 2 → `busy`=1 for those 2 cycles with `haddr` held at 0x104; burst completes in 6 cycles.
- **Round robin**: `req[0]` and `req[2]` held high, `m_len`=0 → grants alternate 0001, 0100, 0001, 0100, with one IDLE cycle between each.
- **Address wrap**: `m_addr`=0xFFFF_FFFC, `m_len`=1 → `haddr` 0xFFFF_FFFC then 0x0000_0000; `done` pulses.
- **Request drop**: deassert `req[3]` after its grant with `m_len`=2 → all 3 beats are still issued and `done` pulses.
